// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and array-update payloads for sram_cache_ctrl.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
package cache_pkg;

  localparam int unsigned DATA_BASE = 1024;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SETS      = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL_LO,
    FILL_HI,
    WRITE
  } state_t;

  // Full-line install on fill completion
  typedef struct packed {
    logic              en;
    logic              way;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } install_t;

  // Single-word update on a write hit
  typedef struct packed {
    logic              en;
    logic              way;
    logic              sel;
    logic [WORD_W-1:0] word;
  } word_upd_t;

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data/LRU storage: async read of both ways of one set, sync install/update.
// Only valid and LRU bits are cleared by rst; tags and data keep their contents.
module cache_array
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             idx,
  output logic [WAYS-1:0]              rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]   rd_tag,
  output logic [WAYS-1:0][LINE_W-1:0]  rd_line,
  output logic                         rd_lru,
  input  install_t                     install,
  input  word_upd_t                    word_upd,
  input  logic                         lru_we,
  input  logic                         lru_val
);

  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [WAYS-1:0][LINE_W-1:0] data_q  [SETS];
  logic [SETS-1:0]             lru_q;

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];
  assign rd_lru   = lru_q[idx];

  // Control bits: cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else begin
      if (install.en) valid_q[idx][install.way] <= 1'b1;
      if (lru_we)     lru_q[idx] <= lru_val;
    end
  end

  // Payload storage: no reset
  always_ff @(posedge clk) begin
    if (install.en) begin
      tag_q[idx][install.way]  <= install.tag;
      data_q[idx][install.way] <= install.line;
    end else if (word_upd.en) begin
      if (word_upd.sel) data_q[idx][word_upd.way][LINE_W-1:WORD_W] <= word_upd.word;
      else              data_q[idx][word_upd.way][WORD_W-1:0]      <= word_upd.word;
    end
  end

endmodule

// File: rtl/sram_cache_ctrl.sv
// Two-way write-through, no-write-allocate data cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add the hit_count/miss_count ports and counters.
module sram_cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [WORD_W-1:0] sram_address,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata,
  input  logic              sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
`endif
);

  localparam int unsigned OFF_W = TAG_W + IDX_W + 1;

  state_t                      state, next_state;
  logic [OFF_W-1:0]            off;
  logic                        word_sel;
  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            tag;
  logic [WAYS-1:0]             rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][LINE_W-1:0] rd_line;
  logic                        rd_lru;
  logic [WAYS-1:0]             hit_vec;
  logic                        hit, hit_way;
  logic [LINE_W-1:0]           hit_line;
  logic [WORD_W-1:0]           hit_word;
  logic [WORD_W-1:0]           low_q;
  install_t                    install;
  word_upd_t                   word_upd;
  logic                        lru_we, lru_val;

  // Word-granular offset from the cacheable base; the two byte bits are always zero
  assign off      = address[OFF_W+1:2] - OFF_W'(DATA_BASE >> 2);
  assign word_sel = off[0];
  assign idx      = off[IDX_W:1];
  assign tag      = off[OFF_W-1:IDX_W+1];

  cache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .rd_lru   (rd_lru),
    .install  (install),
    .word_upd (word_upd),
    .lru_we   (lru_we),
    .lru_val  (lru_val)
  );

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) hit_vec[w] = rd_valid[w] && (rd_tag[w] == tag);
  end

  assign hit      = |hit_vec;
  assign hit_way  = hit_vec[1];
  assign hit_line = rd_line[hit_way];
  assign hit_word = word_sel ? hit_line[LINE_W-1:WORD_W] : hit_line[WORD_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Low half of the line, held until the high word arrives
  always_ff @(posedge clk) begin
    if (rst)                                low_q <= '0;
    else if (state == FILL_LO && sram_ready) low_q <= sram_rdata;
  end

  // Outputs are gated during rst so nothing partial is installed or reported
  always_comb begin
    next_state   = state;
    ready        = 1'b0;
    rdata        = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    install      = '0;
    word_upd     = '0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_w_en) begin
            next_state = WRITE;
          end else if (mem_r_en) begin
            if (hit) begin
              ready   = 1'b1;
              rdata   = hit_word;
              lru_we  = 1'b1;
              lru_val = !hit_way;
            end else begin
              next_state = FILL_LO;
            end
          end
        end
        FILL_LO: begin
          sram_r_en    = 1'b1;
          sram_address = {address[WORD_W-1:3], 3'b000};
          if (sram_ready) next_state = FILL_HI;
        end
        FILL_HI: begin
          sram_r_en    = 1'b1;
          sram_address = {address[WORD_W-1:3], 3'b100};
          if (sram_ready) begin
            install.en   = 1'b1;
            install.way  = rd_lru;
            install.tag  = tag;
            install.line = {sram_rdata, low_q};
            lru_we       = 1'b1;
            lru_val      = !rd_lru;
            ready        = 1'b1;
            rdata        = word_sel ? sram_rdata : low_q;
            next_state   = IDLE;
          end
        end
        WRITE: begin
          sram_w_en    = 1'b1;
          sram_address = address;
          sram_wdata   = wdata;
          if (sram_ready) begin
            word_upd.en   = hit;
            word_upd.way  = hit_way;
            word_upd.sel  = word_sel;
            word_upd.word = wdata;
            lru_we        = hit;
            lru_val       = !hit_way;
            ready         = 1'b1;
            next_state    = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && ready)    hit_count  <= hit_count + WORD_W'(1);
      if (state == FILL_HI && ready) miss_count <= miss_count + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Scoreboard bench for sram_cache_ctrl: random SRAM latency, reference cache model with true 2-way LRU.
module tb_sram_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = 32'd1024;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  sram_cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Background SRAM contents; 1024/1028 pinned to the directed-test values
  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'd1024) return 32'h1111_1111;
    if (a == 32'd1028) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
  endfunction

  // ---------------- SRAM controller model ----------------
  logic [31:0] sram_mem [logic [31:0]];

  function automatic logic [31:0] sram_get(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sram_ready <= 1'b0;
    end else if (sram_ready) begin
      sram_ready <= 1'b0;
    end else if ((sram_r_en || sram_w_en) && $urandom_range(0, 2) == 0) begin
      sram_ready <= 1'b1;
      if (sram_r_en) sram_rdata <= sram_get(sram_address);
      else           sram_mem[sram_address] = sram_wdata;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit          is_wr;
    bit          exp_hit;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [logic [31:0]];
  int unsigned ref_set [64][$];   // tags per set, most recently used first
  int unsigned m_hits, m_misses;
  int          errors, checks;
  int          rd_p, wr_p;

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) ref_set[s].delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic mon_step();
    exp_t e;
    if (rst) begin
      rd_p = 0;
      wr_p = 0;
      return;
    end
    if (sram_r_en && sram_w_en) chk("sram_excl", 32'(sram_r_en & sram_w_en), 32'd0);
    if (sram_ready && sram_r_en) begin
      chk("fill_addr", sram_address, {address[31:3], (rd_p == 0) ? 3'b000 : 3'b100});
      rd_p++;
    end
    if (sram_ready && sram_w_en) begin
      chk("wr_addr", sram_address, address);
      chk("wr_data", sram_wdata, wdata);
      wr_p++;
    end
    if (ready && (mem_r_en || mem_w_en)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_wr) begin
          chk("wr_sram_writes", 32'(wr_p), 32'd1);
          chk("wr_sram_reads", 32'(rd_p), 32'd0);
        end else begin
          chk("rd_data", rdata, e.data);
          chk("rd_sram_reads", 32'(rd_p), e.exp_hit ? 32'd0 : 32'd2);
          chk("rd_sram_writes", 32'(wr_p), 32'd0);
        end
      end
      rd_p = 0;
      wr_p = 0;
    end
  endtask

  task automatic stop_stuck(input string name);
    errors++;
    checks++;
    $display("FAIL %s: no ready within budget (t=%0t)", name, $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench stopped: %s", name);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int unsigned off, idx, tag, pos;
    bit          found, done;
    off   = a - 32'd1024;
    idx   = (off >> 3) & 63;
    tag   = (off >> 9) & 1023;
    found = 0;
    pos   = 0;
    for (int k = 0; k < ref_set[idx].size(); k++)
      if (!found && ref_set[idx][k] == tag) begin
        found = 1;
        pos   = k;
      end
    e.is_wr   = wr;
    e.exp_hit = found;
    if (wr) begin
      ref_mem[a] = d;
      e.data     = d;
      if (found) begin
        ref_set[idx].delete(pos);
        ref_set[idx].push_front(tag);
      end
    end else begin
      e.data = ref_get(a);
      if (found) begin
        ref_set[idx].delete(pos);
        m_hits++;
      end else begin
        if (ref_set[idx].size() == 2) void'(ref_set[idx].pop_back());
        m_misses++;
      end
      ref_set[idx].push_front(tag);
    end
    sb.push_back(e);
    address  = a;
    wdata    = d;
    mem_w_en = wr;
    mem_r_en = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    done     = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (ready) done = 1;
    end
    if (!done) stop_stuck("req_timeout");
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_idle_outputs(input string tagname);
    chk({tagname, "_ready"}, 32'(ready), 32'd0);
    chk({tagname, "_sram_r_en"}, 32'(sram_r_en), 32'd0);
    chk({tagname, "_sram_w_en"}, 32'(sram_w_en), 32'd0);
    chk({tagname, "_rdata"}, rdata, 32'd0);
    chk({tagname, "_sram_address"}, sram_address, 32'd0);
    chk({tagname, "_sram_wdata"}, sram_wdata, 32'd0);
  endtask

  task automatic check_stats(input string tagname);
`ifdef CACHE_STATS_EN
    chk({tagname, "_hit_count"}, hit_count, 32'(m_hits));
    chk({tagname, "_miss_count"}, miss_count, 32'(m_misses));
`else
    if (tagname.len() < 0) $display("unreachable");
`endif
  endtask

  initial begin
    bit          found;
    logic [31:0] a;
    errors = 0;
    checks = 0;
    rd_p   = 0;
    wr_p   = 0;
    model_clear();
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");
    check_stats("reset");

    // Fill, hit on the other word, write-through then hit on the new value
    do_req(0, 32'd1024, 32'd0);
    do_req(0, 32'd1028, 32'd0);
    do_req(1, 32'd1028, 32'hDEAD_BEEF);
    do_req(0, 32'd1028, 32'd0);

    // LRU replacement within set 0
    do_req(0, 32'd1536, 32'd0);
    do_req(0, 32'd1024, 32'd0);
    do_req(0, 32'd2048, 32'd0);
    do_req(0, 32'd1024, 32'd0);
    do_req(0, 32'd1536, 32'd0);

    // No-write-allocate
    do_req(1, 32'd3072, 32'h0000_0055);
    do_req(0, 32'd3072, 32'd0);

    // Reset in the middle of the high-word fetch
    do_reset();
    address  = 32'd1024;
    mem_r_en = 1'b1;
    found    = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(posedge clk);
      #1;
      if (sram_r_en && sram_address[2] && !sram_ready) found = 1;
    end
    if (!found) stop_stuck("fill_hi_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_r_en = 1'b0;
    model_clear();
    chk("rst_fill_sram_r_en", 32'(sram_r_en), 32'd0);
    chk("rst_fill_ready", 32'(ready), 32'd0);
    do_req(0, 32'd1024, 32'd0);

    // Counter sequence: miss, hit, hit, write
    do_reset();
    do_req(0, 32'd5120, 32'd0);
    do_req(0, 32'd5120, 32'd0);
    do_req(0, 32'd5124, 32'd0);
    do_req(1, 32'd5120, 32'h1234_5678);
    check_stats("stats_seq");

    // Randomized traffic over a few contended sets plus sparse far addresses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'd1024 + ($urandom_range(0, 1023) << 9) + ($urandom_range(0, 63) << 3)
          + ($urandom_range(0, 1) << 2);
      else
        a = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
          + ($urandom_range(0, 1) << 2);
      do_req($urandom_range(0, 9) < 3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    check_stats("random");

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
